// File: rtl/freq_meter_if.sv
// freq_meter_if: bundles the measured input and the measurement results.
//   sig_in      - square wave to measure (asynchronous to the meter clock)
//   period_out  - clkin cycles between the last two rising edges of sig_in
//   high_out    - clkin cycles sig_in was high within that period
//   valid       - one-cycle strobe, new period_out/high_out this cycle
//   timeout     - sticky: no rising edge seen for MAXCNT cycles
//   meas_active - meter is in its MEASURE state
// master: the side that drives sig_in and consumes the results.
// slave : the meter itself.
interface freq_meter_if;
    logic        sig_in;
    logic [31:0] period_out;
    logic [31:0] high_out;
    logic        valid;
    logic        timeout;
    logic        meas_active;

    modport master (
        output sig_in,
        input  period_out, high_out, valid, timeout, meas_active
    );

    modport slave (
        input  sig_in,
        output period_out, high_out, valid, timeout, meas_active
    );
endinterface

// File: rtl/freq_meter.sv
// freq_meter: measures period and high time of a slow square wave in clkin
// cycles. Results are registered and announced by a one-cycle valid strobe;
// a sticky timeout flags an input that stopped toggling.
// Ports:
//   clkin  - meter clock, all state updates on its rising edge
//   reset  - synchronous, active-high; clears everything, back to WAIT_FIRST
//   bus    - freq_meter_if.slave (sig_in in, measurement results out)
// Parameter:
//   MAXCNT - timeout limit in clkin cycles (2 .. 2^32-1)
module freq_meter #(
    parameter logic [31:0] MAXCNT = 32'd50000000
) (
    input  logic         clkin,
    input  logic         reset,
    freq_meter_if.slave  bus
);

    typedef enum logic {WAIT_FIRST = 1'b0, MEASURE = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // r_sync[0] = s1, r_sync[1] = s2, r_sync[2] = s3 (previous s2)
    logic [2:0]  r_sync;
    logic [31:0] r_cnt;
    logic [31:0] r_hcnt;
    logic [31:0] r_period;
    logic [31:0] r_high;
    logic        r_valid;
    logic        r_timeout;

    logic        w_s2;
    logic        w_rise;
    logic        w_tmo;
    logic        w_meas_active;

    assign w_s2   = r_sync[1];
    assign w_rise = r_sync[1] & ~r_sync[2];
    // A rise in the same cycle as the limit wins: the period is still valid.
    assign w_tmo  = (r_state == MEASURE) && !w_rise && (r_cnt >= MAXCNT);

    // State register
    always_ff @(posedge clkin) begin
        if (reset) r_state <= WAIT_FIRST;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_FIRST: if (w_rise) w_state_nxt = MEASURE;
            MEASURE:    if (w_tmo)  w_state_nxt = WAIT_FIRST;
            default:    w_state_nxt = WAIT_FIRST;
        endcase
    end

    // Output logic
    always_comb begin
        w_meas_active = 1'b0;
        if (r_state == MEASURE) w_meas_active = 1'b1;
    end

    // Synchronizer plus edge-history register
    always_ff @(posedge clkin) begin
        if (reset) r_sync <= 3'b000;
        else       r_sync <= {r_sync[1:0], bus.sig_in};
    end

    // Counters and result registers. Counting restarts at 1 on a rise because
    // the rise cycle itself is the first cycle (and first high cycle) of the
    // new period. The timeout path clears cnt, so cnt never exceeds MAXCNT.
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_cnt     <= 32'd0;
            r_hcnt    <= 32'd0;
            r_period  <= 32'd0;
            r_high    <= 32'd0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                WAIT_FIRST: begin
                    if (w_rise) begin
                        r_cnt  <= 32'd1;
                        r_hcnt <= 32'd1;
                    end else begin
                        r_cnt  <= 32'd0;
                        r_hcnt <= 32'd0;
                    end
                end
                MEASURE: begin
                    if (w_rise) begin
                        r_period  <= r_cnt;
                        r_high    <= r_hcnt;
                        r_valid   <= 1'b1;
                        r_timeout <= 1'b0;
                        r_cnt     <= 32'd1;
                        r_hcnt    <= 32'd1;
                    end else if (w_tmo) begin
                        r_timeout <= 1'b1;
                        r_period  <= 32'd0;
                        r_high    <= 32'd0;
                        r_cnt     <= 32'd0;
                        r_hcnt    <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                        if (w_s2) r_hcnt <= r_hcnt + 32'd1;
                    end
                end
                default: begin
                    r_cnt  <= 32'd0;
                    r_hcnt <= 32'd0;
                end
            endcase
        end
    end

    assign bus.period_out  = r_period;
    assign bus.high_out    = r_high;
    assign bus.valid       = r_valid;
    assign bus.timeout     = r_timeout;
    assign bus.meas_active = w_meas_active;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: self-checking bench for freq_meter with MAXCNT = 1000.
// A table of waveform segments drives sig_in; every rising edge that closes
// a full period pushes the expected {period, high} onto a scoreboard queue,
// and a negedge monitor pops and compares on each valid strobe. Hand-written
// sequences cover latency, timeout (low and high), recovery and reset.
module tb_freq_meter;

    localparam int MAXC = 1000;

    typedef struct {
        int p;
        int h;
        int n;
        int exp_p;
        int exp_h;
    } vec_t;

    typedef struct {
        logic [31:0] p;
        logic [31:0] h;
    } exp_t;

    logic clkin = 1'b0;
    logic reset = 1'b1;

    freq_meter_if fm_if ();

    freq_meter #(.MAXCNT(32'd1000)) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (fm_if)
    );

    always #10 clkin = ~clkin;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];
    exp_t prev;
    bit   have_prev = 1'b0;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clkin) begin
        if (fm_if.valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("period_out", fm_if.period_out, e.p);
                chk("high_out", fm_if.high_out, e.h);
                chk("timeout_at_valid", {31'd0, fm_if.timeout}, 32'd0);
                chk("meas_active_at_valid", {31'd0, fm_if.meas_active}, 32'd1);
            end
        end
    end

    // One period of sig_in; each loop iteration is sampled by the next posedge.
    task automatic drive_period(input int p, input int h, input int ep, input int eh);
        for (int i = 0; i < p; i++) begin
            @(posedge clkin);
            #1;
            fm_if.sig_in = (i < h);
            if (i == 0 && have_prev) q.push_back(prev);
        end
        prev.p    = ep;
        prev.h    = eh;
        have_prev = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_period"}, fm_if.period_out, 32'd0);
        chk({tag, "_high"}, fm_if.high_out, 32'd0);
        chk({tag, "_valid"}, {31'd0, fm_if.valid}, 32'd0);
        chk({tag, "_meas_active"}, {31'd0, fm_if.meas_active}, 32'd0);
    endtask

    // edges: posedges to wait until the cycle just before timeout fires.
    task automatic tmo_check(input int edges, input string tag);
        repeat (edges) @(posedge clkin);
        @(negedge clkin);
        chk({tag, "_pre_timeout"}, {31'd0, fm_if.timeout}, 32'd0);
        chk({tag, "_pre_active"}, {31'd0, fm_if.meas_active}, 32'd1);
        @(negedge clkin);
        chk({tag, "_timeout"}, {31'd0, fm_if.timeout}, 32'd1);
        check_idle(tag);
        have_prev = 1'b0;
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{p: 10,  h: 5,  n: 5, exp_p: 10,  exp_h: 5};
        tbl[1] = '{p: 100, h: 50, n: 3, exp_p: 100, exp_h: 50};
        tbl[2] = '{p: 7,   h: 1,  n: 5, exp_p: 7,   exp_h: 1};
        tbl[3] = '{p: 12,  h: 6,  n: 3, exp_p: 12,  exp_h: 6};
        tbl[4] = '{p: 2,   h: 1,  n: 4, exp_p: 2,   exp_h: 1};
        tbl[5] = '{p: 15,  h: 14, n: 3, exp_p: 15,  exp_h: 14};

        fm_if.sig_in = 1'b0;
        repeat (4) @(posedge clkin);
        @(negedge clkin);
        check_idle("in_reset");
        chk("in_reset_timeout", {31'd0, fm_if.timeout}, 32'd0);
        @(posedge clkin);
        #1 reset = 1'b0;
        @(negedge clkin);
        check_idle("after_reset");
        chk("after_reset_timeout", {31'd0, fm_if.timeout}, 32'd0);

        // Table-driven steady-state measurements, including 7 -> 12 change
        foreach (tbl[k])
            for (int n = 0; n < tbl[k].n; n++)
                drive_period(tbl[k].p, tbl[k].h, tbl[k].exp_p, tbl[k].exp_h);

        // Latency: rise set 1 ns before edge N closes the last 15/14 period
        @(posedge clkin);
        @(negedge clkin);
        #9;
        fm_if.sig_in = 1'b1;
        q.push_back(prev);
        for (int j = 0; j < 6; j++) begin
            @(negedge clkin);
            chk($sformatf("latency_cycle%0d", j), {31'd0, fm_if.valid}, (j == 2) ? 32'd1 : 32'd0);
        end

        // Stuck high: last internal rise lands 2 edges after N, so the
        // timeout fires at edge N+1002; we are now just past edge N+5.
        tmo_check(996, "stuck_high");

        // Recovery from the high timeout, then steady toggling
        repeat (3) begin
            @(posedge clkin);
            #1 fm_if.sig_in = 1'b0;
        end
        for (int n = 0; n < 3; n++) drive_period(10, 5, 10, 5);

        // Stuck low: last sampled rise at S+1, timeout at edge S+1003,
        // returned from the task just after edge S+9.
        tmo_check(993, "stuck_low");

        // Restart: first rise keeps the sticky flag and gives no valid
        drive_period(10, 5, 10, 5);
        @(negedge clkin);
        chk("restart_timeout_held", {31'd0, fm_if.timeout}, 32'd1);
        chk("restart_active", {31'd0, fm_if.meas_active}, 32'd1);
        drive_period(10, 5, 10, 5);
        drive_period(10, 5, 10, 5);
        @(negedge clkin);
        chk("restart_timeout_cleared", {31'd0, fm_if.timeout}, 32'd0);

        // Reset four counts into a period (while sig_in is low)
        for (int i = 0; i < 10; i++) begin
            @(posedge clkin);
            #1;
            fm_if.sig_in = (i < 5);
            reset        = (i == 6);
            if (i == 0 && have_prev) q.push_back(prev);
            if (i == 7) begin
                @(negedge clkin);
                check_idle("mid_reset");
                chk("mid_reset_timeout", {31'd0, fm_if.timeout}, 32'd0);
            end
        end
        have_prev = 1'b0;
        for (int n = 0; n < 3; n++) drive_period(10, 5, 10, 5);

        repeat (6) @(negedge clkin);
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
